// File: rtl/i2s_target_transmit.sv
// i2s_target_transmit
//   I2S (Philips alignment) serial-data transmitter. It follows the sck/ws
//   pair driven by an external clock master and generates no I2S clocks.
//   One stereo frame is accepted at a time into a single-frame holding buffer
//   and shifted out MSB first, one sck period after each ws transition.
//
// Ports
//   clk            system clock, all logic on the rising edge
//   reset          synchronous active-high reset
//   sck, ws        I2S bit clock / word select from the master (asynchronous)
//   s_valid        frame offered on s_left / s_right
//   s_ready        buffer empty, a frame can be accepted
//   s_left/s_right left / right channel words
//   sd             serial data out
//   frame_start    one-clk pulse at each detected left-slot start
//   underrun       one-clk pulse when a left slot starts with no frame buffered
//   underrun_count saturating count of underruns
module i2s_target_transmit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sck,
    input  logic                  ws,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_left,
    input  logic [DATA_WIDTH-1:0] s_right,
    output logic                  sd,
    output logic                  frame_start,
    output logic                  underrun,
    output logic [CNT_WIDTH-1:0]  underrun_count
);

    // sck_pipe_reg: [0] first sync stage, [1] synchronized sck, [2] history
    logic [2:0]            sck_pipe_reg;
    logic [1:0]            ws_pipe_reg;
    logic                  ws_last_reg,    ws_last_next;
    logic                  synced_reg,     synced_next;
    logic                  buf_full_reg,   buf_full_next;
    logic [DATA_WIDTH-1:0] buf_left_reg,   buf_left_next;
    logic [DATA_WIDTH-1:0] buf_right_reg,  buf_right_next;
    logic [DATA_WIDTH-1:0] right_hold_reg, right_hold_next;
    logic [DATA_WIDTH-1:0] shreg_reg,      shreg_next;
    logic                  sd_reg,         sd_next;
    logic                  frame_start_reg, frame_start_next;
    logic                  underrun_reg,   underrun_next;
    logic [CNT_WIDTH-1:0]  count_reg,      count_next;

    logic sck_fall;
    logic ws_s;
    logic accept;

    assign sck_fall = sck_pipe_reg[2] & ~sck_pipe_reg[1];
    assign ws_s     = ws_pipe_reg[1];
    assign accept   = s_valid & ~buf_full_reg;

    always_comb begin
        ws_last_next     = ws_last_reg;
        synced_next      = synced_reg;
        buf_full_next    = buf_full_reg;
        buf_left_next    = buf_left_reg;
        buf_right_next   = buf_right_reg;
        right_hold_next  = right_hold_reg;
        shreg_next       = shreg_reg;
        sd_next          = sd_reg;
        frame_start_next = 1'b0;
        underrun_next    = 1'b0;
        count_next       = count_reg;

        // accept and consume never coincide: accept needs buf_full low,
        // consume needs it high.
        if (accept) begin
            buf_full_next  = 1'b1;
            buf_left_next  = s_left;
            buf_right_next = s_right;
        end

        if (sck_fall) begin
            // On a boundary the outgoing bit is the LSB of the previous word;
            // the new word's MSB leaves on the following fall (one-sck delay).
            sd_next = shreg_reg[DATA_WIDTH-1];
            if (ws_s != ws_last_reg) begin
                ws_last_next = ws_s;
                if (!ws_s) begin
                    frame_start_next = 1'b1;
                    synced_next      = 1'b1;
                    if (buf_full_reg) begin
                        shreg_next      = buf_left_reg;
                        right_hold_next = buf_right_reg;
                        buf_full_next   = 1'b0;
                    end else begin
                        shreg_next      = '0;
                        right_hold_next = '0;
                        underrun_next   = 1'b1;
                        if (count_reg != '1) begin
                            count_next = count_reg + CNT_WIDTH'(1);
                        end
                    end
                end else begin
                    // A right slot seen before the first left start is a
                    // partial frame and is sent as zeros.
                    shreg_next = synced_reg ? right_hold_reg : '0;
                end
            end else begin
                shreg_next = {shreg_reg[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_pipe_reg    <= '0;
            // ws sync stages start at 1 to agree with ws_last, so leaving
            // reset can never fake a channel boundary.
            ws_pipe_reg     <= '1;
            ws_last_reg     <= 1'b1;
            synced_reg      <= 1'b0;
            buf_full_reg    <= 1'b0;
            buf_left_reg    <= '0;
            buf_right_reg   <= '0;
            right_hold_reg  <= '0;
            shreg_reg       <= '0;
            sd_reg          <= 1'b0;
            frame_start_reg <= 1'b0;
            underrun_reg    <= 1'b0;
            count_reg       <= '0;
        end else begin
            sck_pipe_reg    <= {sck_pipe_reg[1:0], sck};
            ws_pipe_reg     <= {ws_pipe_reg[0], ws};
            ws_last_reg     <= ws_last_next;
            synced_reg      <= synced_next;
            buf_full_reg    <= buf_full_next;
            buf_left_reg    <= buf_left_next;
            buf_right_reg   <= buf_right_next;
            right_hold_reg  <= right_hold_next;
            shreg_reg       <= shreg_next;
            sd_reg          <= sd_next;
            frame_start_reg <= frame_start_next;
            underrun_reg    <= underrun_next;
            count_reg       <= count_next;
        end
    end

    assign s_ready        = ~buf_full_reg;
    assign sd             = sd_reg;
    assign frame_start    = frame_start_reg;
    assign underrun       = underrun_reg;
    assign underrun_count = count_reg;

endmodule

// File: tb/tb_i2s_target_transmit.sv
// tb_i2s_target_transmit
//   Drives an I2S master pattern (clk 20 ns, sck = clk/8, ws period 64 sck)
//   into i2s_target_transmit. Expected slot words are queued with their frame
//   number and channel when stimulus is applied; a monitor assembles sd bits
//   sampled on sck rises and compares each completed slot against the queue.
//   A second instance with CNT_WIDTH=2 never receives frames and exercises
//   the saturating underrun counter.
module tb_i2s_target_transmit;

    typedef struct {
        int          frame;
        int          ch;
        logic [31:0] word;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        sck;
    logic        ws;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_left;
    logic [31:0] s_right;
    logic        sd;
    logic        frame_start;
    logic        underrun;
    logic [15:0] underrun_count;

    logic        sat_s_ready;
    logic        sat_sd;
    logic        sat_frame_start;
    logic        sat_underrun;
    logic [1:0]  sat_count;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          ur_cnt = 0;
    int          sat_ur_cnt = 0;
    int          fs_cnt = 0;
    logic [31:0] word_acc = '0;
    logic        ready_before;
    int          fall_n;

    always #10 clk = ~clk;

    i2s_target_transmit #(.DATA_WIDTH(32), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .reset(reset), .sck(sck), .ws(ws),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_left(s_left), .s_right(s_right),
        .sd(sd), .frame_start(frame_start), .underrun(underrun),
        .underrun_count(underrun_count)
    );

    i2s_target_transmit #(.DATA_WIDTH(32), .CNT_WIDTH(2)) u_sat (
        .clk(clk), .reset(reset), .sck(sck), .ws(ws),
        .s_valid(1'b0), .s_ready(sat_s_ready),
        .s_left(32'h0), .s_right(32'h0),
        .sd(sat_sd), .frame_start(sat_frame_start), .underrun(sat_underrun),
        .underrun_count(sat_count)
    );

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (frame_start === 1'b1)  fs_cnt     <= fs_cnt + 1;
        if (underrun === 1'b1)     ur_cnt     <= ur_cnt + 1;
        if (sat_underrun === 1'b1) sat_ur_cnt <= sat_ur_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Slot starting at fall s belongs to frame s/64; ch 0 = left, 1 = right.
    task automatic score_word(input int n);
        int   tf;
        int   tc;
        exp_t e;
        tf = (n - 32) / 64;
        tc = ((n - 32) / 32) % 2;
        if (exp_q.size() > 0) begin
            e = exp_q[0];
            if (e.frame < tf || (e.frame == tf && e.ch < tc)) begin
                void'(exp_q.pop_front());
                n_checks++;
                n_fail++;
                $error("FAIL slot_missed f%0d ch%0d: observed none expected %h", e.frame, e.ch, e.word);
            end else if (e.frame == tf && e.ch == tc) begin
                void'(exp_q.pop_front());
                n_checks++;
                assert (word_acc === e.word) else begin
                    n_fail++;
                    $error("FAIL slot f%0d ch%0d: observed %h expected %h", tf, tc, word_acc, e.word);
                end
                $display("slot f%0d ch%0d sd_word=%h expected=%h", tf, tc, word_acc, e.word);
            end
        end
    endtask

    // I2S master: ws changes with sck falling; sd sampled on sck rising.
    // All sck edges land on clk falling edges.
    initial begin
        sck    = 1'b1;
        ws     = 1'b1;
        fall_n = 40;
        #40;
        forever begin
            sck = 1'b0;
            ws  = ((fall_n / 32) % 2) != 0;
            #80;
            sck = 1'b1;
            word_acc = {word_acc[30:0], sd};
            if (fall_n % 32 == 0 && fall_n >= 64) score_word(fall_n);
            #80;
            fall_n++;
        end
    end

    // Returns one clk after the frame_start pulse; ready_before holds s_ready
    // from the clk before the pulse.
    task automatic wait_fs(input string tag);
        int n;
        n = 0;
        ready_before = s_ready;
        while (frame_start !== 1'b1 && n < 1500) begin
            ready_before = s_ready;
            @(negedge clk);
            n++;
        end
        chk({tag, "_frame_start"}, {31'b0, frame_start}, 32'd1);
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] l, input logic [31:0] r);
        int n;
        n = 0;
        while (s_ready !== 1'b1 && n < 1500) begin
            @(negedge clk);
            n++;
        end
        s_left  = l;
        s_right = r;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        $display("push left=%h right=%h", l, r);
    endtask

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_left  = '0;
        s_right = '0;

        // Reset held 3 clk while sck/ws run.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_sd", {31'b0, sd}, 32'd0);
            chk("reset_s_ready", {31'b0, s_ready}, 32'd1);
            chk("reset_count", {16'b0, underrun_count}, 32'd0);
        end
        reset = 1'b0;

        // Partial right slot before sync must be all zeros.
        exp_q.push_back('{0, 1, 32'h0});
        exp_q.push_back('{1, 0, 32'hAAAAAAAA});
        exp_q.push_back('{1, 1, 32'h12345678});
        push(32'hAAAAAAAA, 32'h12345678);
        chk("accept_s_ready_low", {31'b0, s_ready}, 32'd0);
        repeat (20) @(negedge clk);
        chk("presync_sd", {31'b0, sd}, 32'd0);
        chk("presync_count", {16'b0, underrun_count}, 32'd0);
        chk("presync_no_fs", fs_cnt, 32'd0);

        wait_fs("frame1");
        chk("f1_ready_before", {31'b0, ready_before}, 32'd0);
        chk("f1_ready_after", {31'b0, s_ready}, 32'd1);
        chk("f1_count", {16'b0, underrun_count}, 32'd0);
        chk("f1_ur_pulses", ur_cnt, 32'd0);
        chk("f1_fs_once", fs_cnt, 32'd1);

        // Three frames with nothing buffered.
        for (int f = 2; f <= 4; f++) begin
            exp_q.push_back('{f, 0, 32'h0});
            exp_q.push_back('{f, 1, 32'h0});
        end
        for (int f = 2; f <= 4; f++) begin
            wait_fs("underrun_frame");
            chk("ur_count", {16'b0, underrun_count}, f - 1);
            chk("ur_pulses", ur_cnt, f - 1);
            chk("sat_count", {30'b0, sat_count}, (f >= 3) ? 3 : f);
            chk("sat_pulses", sat_ur_cnt, f);
        end

        // s_valid held high across two frames F0 then F1.
        exp_q.push_back('{5, 0, 32'h80000001});
        exp_q.push_back('{5, 1, 32'h7FFFFFFE});
        exp_q.push_back('{6, 0, 32'hDEADBEEF});
        exp_q.push_back('{6, 1, 32'h0});
        s_left  = 32'h80000001;
        s_right = 32'h7FFFFFFE;
        s_valid = 1'b1;
        @(negedge clk);
        chk("f0_accepted", {31'b0, s_ready}, 32'd0);
        s_left  = 32'hDEADBEEF;
        s_right = 32'h0;
        wait_fs("frame5");
        chk("f5_ready_before", {31'b0, ready_before}, 32'd0);
        repeat (2) @(negedge clk);
        chk("f1_held", {31'b0, s_ready}, 32'd0);
        s_valid = 1'b0;
        chk("f5_count", {16'b0, underrun_count}, 32'd3);
        chk("sat_count_5", {30'b0, sat_count}, 32'd3);
        chk("sat_pulses_5", sat_ur_cnt, 32'd5);
        wait_fs("frame6");
        chk("f6_ready_before", {31'b0, ready_before}, 32'd0);
        chk("f6_count", {16'b0, underrun_count}, 32'd3);
        chk("f6_ready_after", {31'b0, s_ready}, 32'd1);

        // Frame 7 carries G; H is buffered then lost to a mid-right-slot reset.
        exp_q.push_back('{7, 0, 32'h13579BDF});
        push(32'h13579BDF, 32'hFFFFFFFF);
        wait_fs("frame7");
        push(32'hABCDEF01, 32'h00000001);
        repeat (384) @(negedge clk);
        chk("pre_reset_sd", {31'b0, sd}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_sd", {31'b0, sd}, 32'd0);
        chk("rst_s_ready", {31'b0, s_ready}, 32'd1);
        chk("rst_count", {16'b0, underrun_count}, 32'd0);
        reset = 1'b0;
        exp_q.push_back('{8, 0, 32'h0});
        exp_q.push_back('{8, 1, 32'h0});
        exp_q.push_back('{9, 0, 32'hCAFEF00D});
        exp_q.push_back('{9, 1, 32'h0F0F0F0F});
        wait_fs("frame8");
        chk("f8_count", {16'b0, underrun_count}, 32'd1);
        chk("f8_s_ready", {31'b0, s_ready}, 32'd1);
        push(32'hCAFEF00D, 32'h0F0F0F0F);
        wait_fs("frame9");
        chk("f9_count", {16'b0, underrun_count}, 32'd1);

        for (int n = 0; n < 1500 && exp_q.size() > 0; n++) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
